// File: rtl/dtc_pingpong_ctrl.sv
// Ping-pong sequencer for the DTC serial path: fetches BRAM words, loads the shift
// register, fills one 1-bit FIFO while the other drains, and swaps only when the drain side is empty.
module dtc_pingpong_ctrl #(
    parameter int WORD_W    = 256,
    parameter int ADDR_W    = 5,
    parameter int NUM_WORDS = 24,
    parameter int BRAM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              load,
    output logic              shift_en,
    output logic [1:0]        buf_wr_en,
    output logic [1:0]        buf_rd_en,
    input  logic [1:0]        buf_full,
    input  logic [1:0]        buf_empty,
    output logic              rd_sel,
    output logic              word_done,
    output logic              frame_done,
    output logic              busy,
    output logic              overflow_err,
    output logic [15:0]       stall_cnt
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int LAT_W = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;

    localparam logic [CNT_W-1:0]  SHIFT_LAST   = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  SHIFT_PENULT = CNT_W'((WORD_W >= 2) ? WORD_W - 2 : 0);
    localparam logic [LAT_W-1:0]  LAT_LAST     = LAT_W'(BRAM_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST    = ADDR_W'(NUM_WORDS - 1);
    localparam bit                ONE_BIT_WORD = (WORD_W == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_SWAP
    } state_t;

    state_t            r_state;
    logic              r_wsel;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [ADDR_W-1:0] r_bram_addr;
    logic              r_load;
    logic              r_shift_en;
    logic              r_word_done;
    logic              r_frame_done;
    logic              r_busy;
    logic              r_overflow_err;
    logic [15:0]       r_stall_cnt;

    logic              w_rd_sel;
    logic              w_wr_full;
    logic              w_rd_empty;
    logic              w_last_addr;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_rd_sel    = ~r_wsel;
    assign w_wr_full   = buf_full[r_wsel];
    assign w_rd_empty  = buf_empty[w_rd_sel];
    assign w_last_addr = (r_bram_addr == ADDR_LAST);
    assign w_next_addr = w_last_addr ? '0 : r_bram_addr + ADDR_W'(1);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wsel         <= 1'b0;
            r_bit_cnt      <= '0;
            r_lat_cnt      <= '0;
            r_bram_addr    <= '0;
            r_load         <= 1'b0;
            r_shift_en     <= 1'b0;
            r_word_done    <= 1'b0;
            r_frame_done   <= 1'b0;
            r_busy         <= 1'b0;
            r_overflow_err <= 1'b0;
            r_stall_cnt    <= '0;
        end else begin
            r_load       <= 1'b0;
            r_word_done  <= 1'b0;
            r_frame_done <= 1'b0;

            // A full fill-side FIFO drops this bit; the word length is unaffected.
            if (r_shift_en && w_wr_full) begin
                r_overflow_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state   <= S_FETCH;
                        r_lat_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_state <= S_LOAD;
                        r_load  <= 1'b1;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                    end
                end

                S_LOAD: begin
                    r_state    <= S_SHIFT;
                    r_shift_en <= 1'b1;
                    r_bit_cnt  <= '0;
                    if (ONE_BIT_WORD) begin
                        r_word_done  <= 1'b1;
                        r_frame_done <= w_last_addr;
                    end
                end

                S_SHIFT: begin
                    if (r_bit_cnt == SHIFT_LAST) begin
                        r_state    <= S_SWAP;
                        r_shift_en <= 1'b0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                    // Word pulses are registered one cycle early so they line up with the last shift_en.
                    if (!ONE_BIT_WORD && (r_bit_cnt == SHIFT_PENULT)) begin
                        r_word_done  <= 1'b1;
                        r_frame_done <= w_last_addr;
                    end
                end

                S_SWAP: begin
                    if (w_rd_empty) begin
                        r_wsel      <= ~r_wsel;
                        r_bram_addr <= w_next_addr;
                        if (run) begin
                            r_state   <= S_FETCH;
                            r_lat_cnt <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_stall_cnt != 16'hFFFF) begin
                        r_stall_cnt <= r_stall_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_shift_en <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: both enables get a zero default before the conditional writes,
    // which keeps this block purely combinational with no inferred latch.
    always_comb begin
        buf_wr_en = 2'b00;
        buf_rd_en = 2'b00;
        if (r_shift_en) begin
            buf_wr_en[r_wsel] = ~w_wr_full;
        end
        // Draining runs in every state; rst masks it so enables read zero during reset.
        if (!rst) begin
            buf_rd_en[w_rd_sel] = ~w_rd_empty;
        end
    end

    assign bram_addr    = r_bram_addr;
    assign load         = r_load;
    assign shift_en     = r_shift_en;
    assign rd_sel       = w_rd_sel;
    assign word_done    = r_word_done;
    assign frame_done   = r_frame_done;
    assign busy         = r_busy;
    assign overflow_err = r_overflow_err;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_dtc_pingpong_ctrl.sv
// Self-checking bench for dtc_pingpong_ctrl: FIFOs are modelled as occupancy counters,
// and each word's timing, address, and fill target are predicted from word-level arithmetic.
module tb_dtc_pingpong_ctrl;

    localparam int WORD_W    = 256;
    localparam int ADDR_W    = 5;
    localparam int NUM_WORDS = 24;
    localparam int BRAM_LAT  = 1;
    localparam int PERIOD    = BRAM_LAT + 1 + WORD_W + 1;
    localparam logic [31:0] RST_VEC = {5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

    logic              clk;
    logic              rst;
    logic              run;
    logic [ADDR_W-1:0] bram_addr;
    logic              load;
    logic              shift_en;
    logic [1:0]        buf_wr_en;
    logic [1:0]        buf_rd_en;
    logic [1:0]        buf_full;
    logic [1:0]        buf_empty;
    logic              rd_sel;
    logic              word_done;
    logic              frame_done;
    logic              busy;
    logic              overflow_err;
    logic [15:0]       stall_cnt;

    dtc_pingpong_ctrl #(
        .WORD_W   (WORD_W),
        .ADDR_W   (ADDR_W),
        .NUM_WORDS(NUM_WORDS),
        .BRAM_LAT (BRAM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .bram_addr   (bram_addr),
        .load        (load),
        .shift_en    (shift_en),
        .buf_wr_en   (buf_wr_en),
        .buf_rd_en   (buf_rd_en),
        .buf_full    (buf_full),
        .buf_empty   (buf_empty),
        .rd_sel      (rd_sel),
        .word_done   (word_done),
        .frame_done  (frame_done),
        .busy        (busy),
        .overflow_err(overflow_err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int load_cyc;
        int addr;
        int len;
        int w0;
        int w1;
        int wbad;
        int wd_cyc;
        bit frame;
    } word_rec_t;

    word_rec_t  words[$];
    int         load_cyc_q[$];
    int         load_addr_q[$];
    int         cyc;
    int         n_cmp;
    int         n_bad;
    int         fifo_cnt[2];
    int         rd_cycles[2];
    logic [1:0] f_full;
    logic [1:0] f_ez;
    logic [1:0] pend_wr;
    logic [1:0] pend_rd;
    int         acc_len, acc_w0, acc_w1, acc_wbad, cur_load, cur_addr;
    int         frame_cnt;
    int         stray;

    function automatic logic [31:0] out_vec();
        return {bram_addr, load, shift_en, buf_wr_en, buf_rd_en, rd_sel,
                word_done, frame_done, busy, overflow_err, stall_cnt};
    endfunction

    task automatic clear_model();
        words.delete();
        load_cyc_q.delete();
        load_addr_q.delete();
        fifo_cnt  = '{0, 0};
        rd_cycles = '{0, 0};
        f_full    = 2'b00;
        f_ez      = 2'b00;
        pend_wr   = 2'b00;
        pend_rd   = 2'b00;
        acc_len = 0; acc_w0 = 0; acc_w1 = 0; acc_wbad = 0; cur_load = 0; cur_addr = 0;
        frame_cnt = 0;
        stray     = 0;
        buf_empty = 2'b11;
        buf_full  = 2'b00;
    endtask

    // One clock: FIFO model updates just after the edge, DUT is observed at the falling edge.
    task automatic tick();
        word_rec_t rec;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (pend_wr[i] && fifo_cnt[i] < WORD_W) fifo_cnt[i]++;
            if (pend_rd[i] && fifo_cnt[i] > 0) fifo_cnt[i]--;
            buf_empty[i] = (fifo_cnt[i] == 0) && !f_ez[i];
            buf_full[i]  = (fifo_cnt[i] >= WORD_W) || f_full[i];
        end
        cyc++;
        @(negedge clk);
        pend_wr = buf_wr_en;
        pend_rd = buf_rd_en;
        if (load === 1'b1) begin
            cur_load = cyc;
            cur_addr = int'(bram_addr);
            acc_len = 0; acc_w0 = 0; acc_w1 = 0; acc_wbad = 0;
            load_cyc_q.push_back(cyc);
            load_addr_q.push_back(int'(bram_addr));
        end
        if (shift_en === 1'b1) begin
            acc_len++;
            if (buf_wr_en === 2'b01) acc_w0++;
            else if (buf_wr_en === 2'b10) acc_w1++;
            else if (buf_wr_en !== 2'b00) acc_wbad++;
        end else if (buf_wr_en !== 2'b00) begin
            stray++;
        end
        if (buf_rd_en === 2'b11) stray++;
        if (buf_rd_en[0] === 1'b1) rd_cycles[0]++;
        if (buf_rd_en[1] === 1'b1) rd_cycles[1]++;
        if (frame_done === 1'b1) begin
            frame_cnt++;
            if (word_done !== 1'b1) stray++;
        end
        if (word_done === 1'b1) begin
            rec.load_cyc = cur_load;
            rec.addr     = cur_addr;
            rec.len      = acc_len;
            rec.w0       = acc_w0;
            rec.w1       = acc_w1;
            rec.wbad     = acc_wbad;
            rec.wd_cyc   = cyc;
            rec.frame    = (frame_done === 1'b1);
            words.push_back(rec);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        clear_model();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && words.size() < n; i++) tick();
        n_cmp++;
        if (words.size() < n) begin
            n_bad++;
            $display("FAIL %s: words seen %0d, required %0d", tag, words.size(), n);
        end
    endtask

    task automatic wait_loads(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && load_cyc_q.size() < n; i++) tick();
        n_cmp++;
        if (load_cyc_q.size() < n) begin
            n_bad++;
            $display("FAIL %s: loads seen %0d, required %0d", tag, load_cyc_q.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && busy !== 1'b0; i++) tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: busy=%b, required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        int idle_viol;
        rst = 1'b1;
        run = 1'b0;
        clear_model();
        tick();
        n_cmp++;
        if (out_vec() !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset_hold: outputs %h, required %h", out_vec(), RST_VEC);
        end
        tick();
        rst = 1'b0;
        idle_viol = 0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0 || load !== 1'b0 || shift_en !== 1'b0) idle_viol++;
        end
        n_cmp++;
        if (out_vec() !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset_release: outputs %h, required %h", out_vec(), RST_VEC);
        end
        n_cmp++;
        if (idle_viol != 0) begin
            n_bad++;
            $display("FAIL reset_idle: %0d active cycles with run=0, required 0", idle_viol);
        end
    endtask

    task automatic test_basic();
        int t0;
        do_reset();
        t0  = cyc;
        run = 1'b1;
        wait_words(3, 3 * PERIOD + 20, "basic_wait");
        run = 1'b0;
        for (int k = 0; k < 3 && k < words.size(); k++) begin
            n_cmp++;
            if (words[k].load_cyc != t0 + 2 + PERIOD * k) begin
                n_bad++;
                $display("FAIL basic_load_time[%0d]: got %0d, want %0d", k, words[k].load_cyc - t0, 2 + PERIOD * k);
            end
            n_cmp++;
            if (words[k].addr != k % NUM_WORDS) begin
                n_bad++;
                $display("FAIL basic_addr[%0d]: got %0d, want %0d", k, words[k].addr, k % NUM_WORDS);
            end
            n_cmp++;
            if (words[k].len != WORD_W || words[k].wd_cyc - words[k].load_cyc != WORD_W) begin
                n_bad++;
                $display("FAIL basic_shift_len[%0d]: got len %0d span %0d, want %0d", k, words[k].len,
                         words[k].wd_cyc - words[k].load_cyc, WORD_W);
            end
            n_cmp++;
            if (words[k].w0 != ((k % 2 == 0) ? WORD_W : 0) || words[k].w1 != ((k % 2 == 1) ? WORD_W : 0) ||
                words[k].wbad != 0) begin
                n_bad++;
                $display("FAIL basic_wr_target[%0d]: got w0=%0d w1=%0d bad=%0d, want fifo %0d x%0d", k,
                         words[k].w0, words[k].w1, words[k].wbad, k % 2, WORD_W);
            end
        end
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0 || bram_addr !== 5'd3 || stall_cnt !== 16'd0 || stray != 0) begin
            n_bad++;
            $display("FAIL basic_end: got busy=%b addr=%0d stall=%0d stray=%0d, want 0/3/0/0",
                     busy, bram_addr, stall_cnt, stray);
        end
    endtask

    task automatic test_frame_wrap();
        int frame_bad, addr_bad;
        do_reset();
        run = 1'b1;
        wait_loads(NUM_WORDS + 1, (NUM_WORDS + 1) * PERIOD + 20, "wrap_wait_loads");
        run = 1'b0;
        wait_words(NUM_WORDS + 1, PERIOD + 20, "wrap_wait_words");
        tick();
        tick();
        frame_bad = 0;
        addr_bad  = 0;
        for (int k = 0; k < words.size(); k++) begin
            if (words[k].frame != (k % NUM_WORDS == NUM_WORDS - 1)) frame_bad++;
            if (words[k].addr != k % NUM_WORDS) addr_bad++;
        end
        n_cmp++;
        if (frame_cnt != 1 || frame_bad != 0) begin
            n_bad++;
            $display("FAIL wrap_frame_done: got %0d pulses, %0d misplaced; want 1 on word %0d",
                     frame_cnt, frame_bad, NUM_WORDS - 1);
        end
        n_cmp++;
        if (addr_bad != 0) begin
            n_bad++;
            $display("FAIL wrap_addr_seq: got %0d wrong word addresses, want 0", addr_bad);
        end
        if (load_addr_q.size() > NUM_WORDS) begin
            n_cmp++;
            if (load_addr_q[NUM_WORDS] != 0) begin
                n_bad++;
                $display("FAIL wrap_25th_load: got addr %0d, want 0", load_addr_q[NUM_WORDS]);
            end
        end
        n_cmp++;
        if (bram_addr !== 5'd1 || busy !== 1'b0 || stray != 0) begin
            n_bad++;
            $display("FAIL wrap_end: got addr=%0d busy=%b stray=%0d, want 1/0/0", bram_addr, busy, stray);
        end
    endtask

    task automatic test_stall();
        int   stalls[4];
        int   exp_stall;
        int   viol;
        logic rd_before;
        do_reset();
        stalls[0] = 10;
        stalls[1] = int'($urandom_range(1, 15));
        stalls[2] = 0;
        stalls[3] = int'($urandom_range(1, 15));
        exp_stall = 0;
        viol      = 0;
        run       = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_words(j + 1, PERIOD + 60, "stall_wait");
            if (j == 3) run = 1'b0;
            rd_before = rd_sel;
            if (stalls[j] > 0) begin
                f_ez[rd_before] = 1'b1;
                repeat (stalls[j]) begin
                    tick();
                    if (shift_en !== 1'b0 || load !== 1'b0 || rd_sel !== rd_before) viol++;
                end
                f_ez = 2'b00;
            end
            exp_stall += stalls[j];
            if (j == 0) begin
                tick();
                n_cmp++;
                if (stall_cnt !== 16'(exp_stall)) begin
                    n_bad++;
                    $display("FAIL stall_first: got %0d, want %0d", stall_cnt, exp_stall);
                end
                tick();
                n_cmp++;
                if (rd_sel !== ~rd_before) begin
                    n_bad++;
                    $display("FAIL stall_swap: got rd_sel=%b, want %b", rd_sel, ~rd_before);
                end
            end
        end
        wait_idle(PERIOD, "stall_idle");
        n_cmp++;
        if (viol != 0) begin
            n_bad++;
            $display("FAIL stall_hold: got %0d cycles leaving SWAP early, want 0", viol);
        end
        n_cmp++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_bad++;
            $display("FAIL stall_total: got %0d, want %0d", stall_cnt, exp_stall);
        end
        for (int j = 0; j < 3 && j + 1 < words.size(); j++) begin
            n_cmp++;
            if (words[j + 1].load_cyc - words[j].wd_cyc != BRAM_LAT + 2 + stalls[j]) begin
                n_bad++;
                $display("FAIL stall_gap[%0d]: got %0d, want %0d", j, words[j + 1].load_cyc - words[j].wd_cyc,
                         BRAM_LAT + 2 + stalls[j]);
            end
        end
    endtask

    task automatic test_overflow();
        int s, blocked;
        do_reset();
        s   = int'($urandom_range(0, 250));
        run = 1'b1;
        wait_loads(2, 2 * PERIOD + 20, "ovf_wait_load");
        repeat (s) tick();
        n_cmp++;
        if (overflow_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_early: got %b, want 0", overflow_err);
        end
        f_full[1] = 1'b1;
        blocked   = 0;
        repeat (3) begin
            tick();
            if (buf_wr_en[1] === 1'b0 && shift_en === 1'b1) blocked++;
        end
        f_full = 2'b00;
        n_cmp++;
        if (blocked != 3) begin
            n_bad++;
            $display("FAIL ovf_blocked: got %0d gated shift cycles, want 3", blocked);
        end
        tick();
        n_cmp++;
        if (overflow_err !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_flag: got %b, want 1", overflow_err);
        end
        wait_words(3, 2 * PERIOD + 20, "ovf_wait_words");
        run = 1'b0;
        wait_idle(PERIOD, "ovf_idle");
        if (words.size() >= 3) begin
            n_cmp++;
            if (words[1].len != WORD_W || words[1].wd_cyc - words[1].load_cyc != WORD_W ||
                words[1].w1 != WORD_W - 3 || words[1].w0 != 0) begin
                n_bad++;
                $display("FAIL ovf_word: got len=%0d w1=%0d w0=%0d, want %0d/%0d/0", words[1].len,
                         words[1].w1, words[1].w0, WORD_W, WORD_W - 3);
            end
            n_cmp++;
            if (words[2].w0 != WORD_W || words[0].w0 != WORD_W) begin
                n_bad++;
                $display("FAIL ovf_neighbours: got w0=%0d,%0d, want %0d", words[0].w0, words[2].w0, WORD_W);
            end
        end
        n_cmp++;
        if (overflow_err !== 1'b1 || stray != 0) begin
            n_bad++;
            $display("FAIL ovf_sticky: got flag=%b stray=%0d, want 1/0", overflow_err, stray);
        end
    endtask

    task automatic test_stop_restart();
        int t, idle_viol;
        do_reset();
        run = 1'b1;
        wait_loads(1, PERIOD, "stop_wait_load");
        repeat (100) tick();
        run = 1'b0;
        wait_words(1, PERIOD, "stop_wait_word");
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0 || bram_addr !== 5'd1 || rd_sel !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_idle: got busy=%b addr=%0d rd_sel=%b, want 0/1/0", busy, bram_addr, rd_sel);
        end
        idle_viol = 0;
        repeat (300) begin
            tick();
            if (busy !== 1'b0 || load !== 1'b0) idle_viol++;
        end
        n_cmp++;
        if (rd_cycles[0] != WORD_W || fifo_cnt[0] != 0 || buf_rd_en !== 2'b00 || idle_viol != 0) begin
            n_bad++;
            $display("FAIL stop_drain: got reads=%0d left=%0d rd_en=%b viol=%0d, want %0d/0/00/0",
                     rd_cycles[0], fifo_cnt[0], buf_rd_en, idle_viol, WORD_W);
        end
        if (words.size() > 0) begin
            n_cmp++;
            if (words[0].w0 != WORD_W || words[0].len != WORD_W) begin
                n_bad++;
                $display("FAIL stop_word: got w0=%0d len=%0d, want %0d", words[0].w0, words[0].len, WORD_W);
            end
        end
        t   = cyc;
        run = 1'b1;
        wait_loads(2, 20, "restart_wait_load");
        if (load_cyc_q.size() >= 2) begin
            n_cmp++;
            if (load_cyc_q[1] != t + 2 || load_addr_q[1] != 1) begin
                n_bad++;
                $display("FAIL restart_load: got t+%0d addr %0d, want t+2 addr 1", load_cyc_q[1] - t, load_addr_q[1]);
            end
        end
        wait_words(2, PERIOD, "restart_wait_word");
        run = 1'b0;
        wait_idle(PERIOD, "restart_idle");
        if (words.size() >= 2) begin
            n_cmp++;
            if (words[1].w1 != WORD_W || words[1].w0 != 0) begin
                n_bad++;
                $display("FAIL restart_target: got w1=%0d w0=%0d, want %0d/0", words[1].w1, words[1].w0, WORD_W);
            end
        end
    endtask

    task automatic test_async_reset();
        int t;
        do_reset();
        run = 1'b1;
        wait_loads(2, 2 * PERIOD + 20, "arst_wait_load");
        repeat (50) tick();
        n_cmp++;
        if (shift_en !== 1'b1 || buf_wr_en !== 2'b10 || buf_rd_en !== 2'b01 || bram_addr !== 5'd1) begin
            n_bad++;
            $display("FAIL arst_pre: got shift=%b wr=%b rd=%b addr=%0d, want 1/10/01/1",
                     shift_en, buf_wr_en, buf_rd_en, bram_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_vec() !== RST_VEC) begin
            n_bad++;
            $display("FAIL arst_immediate: outputs %h, required %h", out_vec(), RST_VEC);
        end
        run = 1'b0;
        clear_model();
        tick();
        tick();
        rst = 1'b0;
        t   = cyc;
        run = 1'b1;
        wait_loads(1, 20, "arst_restart_load");
        if (load_cyc_q.size() >= 1) begin
            n_cmp++;
            if (load_cyc_q[0] != t + 2 || load_addr_q[0] != 0) begin
                n_bad++;
                $display("FAIL arst_restart: got t+%0d addr %0d, want t+2 addr 0", load_cyc_q[0] - t, load_addr_q[0]);
            end
        end
        wait_words(1, PERIOD, "arst_wait_word");
        run = 1'b0;
        wait_idle(PERIOD, "arst_idle");
        if (words.size() >= 1) begin
            n_cmp++;
            if (words[0].w0 != WORD_W || words[0].w1 != 0) begin
                n_bad++;
                $display("FAIL arst_target: got w0=%0d w1=%0d, want %0d/0", words[0].w0, words[0].w1, WORD_W);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst   = 1'b1;
        run   = 1'b0;
        clear_model();
        test_reset();
        test_basic();
        test_frame_wrap();
        test_stall();
        test_overflow();
        test_stop_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
